dec2x4_seq: RTL and testbench
=============================

DEC2X4_SEQ -- requirements
Module: dec2x4_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 2, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of decoded-word counter.
REQ-003 SHALL have port clk, input, 1, single clock; all state rises on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port flush, input, 1, synchronous clear of FIFO contents.
REQ-006 SHALL have port in_valid, input, 1, in_code is valid.
REQ-007 SHALL have port in_code, input, 2, binary code {y1,y0} from the 4x2 encoder.
REQ-008 SHALL have port in_ready, output, 1, block accepts a code this cycle.
REQ-009 SHALL have port out_valid, output, 1, out_onehot is valid.
REQ-010 SHALL have port out_onehot, output, 4, decoded line {x4,x3,x2,x1}.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_onehot.
REQ-012 SHALL have port count, output, CNT_W, decoded-word counter (see REQ-029).

Function
REQ-013 SHALL decode 00->0001, 01->0010, 10->0100, 11->1000, exactly inverse to the 4x2 encoder map.
REQ-014 SHALL push when in_valid && in_ready; pop when out_valid && out_ready.
REQ-015 SHALL drive in_ready = (occupancy < DEPTH) && !flush; no pass-through when full.
REQ-016 SHALL drive out_valid = (occupancy > 0); out_onehot = decoded head entry, else 0000.
REQ-017 SHALL give latency of 1 cycle: a code pushed into an empty FIFO at edge N appears on out_onehot after edge N.
REQ-018 SHALL track occupancy states EMPTY, PARTIAL, FULL: push-only +1, pop-only -1, push&pop unchanged.
REQ-019 SHALL allow push and pop in the same cycle in PARTIAL; in FULL only pop is possible.
REQ-020 SHALL wrap read/write pointers modulo DEPTH.
REQ-021 SHALL hold out_onehot and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL, on flush, clear occupancy and pointers at next edge; a same-cycle push or pop is discarded.
REQ-023 SHALL never output a non-one-hot value while out_valid=1.
REQ-024 SHALL treat in_code as don't-care when in_valid=0.

Reset
REQ-025 SHALL, on rst=1 asynchronously, clear occupancy, pointers and count.
REQ-026 SHALL hold out_valid=0, out_onehot=0000, count=0 during reset; in_ready=1 in the first cycle after release.
REQ-027 SHALL drop an in-flight transfer when reset is asserted mid-operation; no partial state survives.

Configuration
REQ-028 SHALL provide the macro DEC2X4_SEQ_CNT_EN.
REQ-029 SHALL, with DEC2X4_SEQ_CNT_EN defined, increment count by 1 per pop, saturating at 2^CNT_W-1, cleared by rst and flush.
REQ-030 SHALL, without DEC2X4_SEQ_CNT_EN, tie count to 0 and instantiate no counter flops.

Structure
REQ-031 SHALL use package dec2x4_pkg holding code_t (2-bit), onehot_t (4-bit), the constants LINE_X1..LINE_X4 and function decode().
REQ-032 SHALL place storage in sub-module dec2x4_fifo (entries of code_t, DEPTH param), with decoding applied at its read port.

Verification
REQ-033 SHALL cover this scenario: after reset, push 00,01,10,11 with out_ready=1 -> out_onehot 0001,0010,0100,1000 on consecutive cycles, each one cycle after push.
REQ-034 SHALL cover this scenario: with out_ready=0, push 10,11 -> in_ready=0 after 2nd push; 3rd push of 01 is ignored; release -> 0100 then 1000.
REQ-035 SHALL cover this scenario: in PARTIAL, simultaneous push 01 and pop -> occupancy unchanged; order preserved.
REQ-036 SHALL cover this scenario: with 2 entries stored, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, and the input is dropped.
REQ-037 SHALL cover this scenario: rst asserted mid-stream between edges -> out_valid=0 and out_onehot=0000 immediately; first push after release decodes correctly.
REQ-038 SHALL cover this scenario: with DEC2X4_SEQ_CNT_EN and CNT_W=4, 20 pops -> count stops at 15; without the macro, count=0 throughout.

Source files
------------

// File: rtl/dec2x4_pkg.sv
// dec2x4_pkg: code/one-hot types, decoded line constants and the 2-to-4 decode map
package dec2x4_pkg;
  typedef logic [1:0] code_t;
  typedef logic [3:0] onehot_t;
  localparam onehot_t LINE_X1 = 4'b0001;
  localparam onehot_t LINE_X2 = 4'b0010;
  localparam onehot_t LINE_X3 = 4'b0100;
  localparam onehot_t LINE_X4 = 4'b1000;
  function automatic onehot_t decode(input code_t c);
    return c == 2'd0 ? LINE_X1 : c == 2'd1 ? LINE_X2 : c == 2'd2 ? LINE_X3 : LINE_X4;
  endfunction
endpackage

// File: rtl/dec2x4_fifo.sv
// dec2x4_fifo: DEPTH-entry code FIFO with EMPTY/PARTIAL/FULL tracking, decoding at the read port
module dec2x4_fifo
  import dec2x4_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    wr_en,
  input  code_t   wr_code,
  input  logic    rd_en,
  output logic    full,
  output logic    empty,
  output onehot_t rd_onehot
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [1:0] ST_EMPTY = 2'd0, ST_PARTIAL = 2'd1, ST_FULL = 2'd2;
  logic [PTR_W:0] occ;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0] state;
  logic push, pop;
  code_t mem [DEPTH];
  always_comb begin
    state = occ == '0 ? ST_EMPTY : occ == (PTR_W+1)'(DEPTH) ? ST_FULL : ST_PARTIAL;
    full = state == ST_FULL;
    empty = state == ST_EMPTY;
    push = wr_en && !full && !flush;
    pop = rd_en && !empty && !flush;
    rd_onehot = empty ? '0 : decode(mem[rd_ptr]);
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      occ <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      occ <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_code;
endmodule

// File: rtl/dec2x4_seq.sv
// dec2x4_seq: buffered 2-to-4 decoder with valid/ready handshake on both sides.
// Define DEC2X4_SEQ_CNT_EN to enable the saturating decoded-word counter on count.
module dec2x4_seq
  import dec2x4_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  code_t            in_code,
  output logic             in_ready,
  output logic             out_valid,
  output onehot_t          out_onehot,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);
  logic full, empty;
  dec2x4_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr_en(in_valid),
    .wr_code(in_code),
    .rd_en(out_ready),
    .full(full),
    .empty(empty),
    .rd_onehot(out_onehot)
  );
  assign in_ready = !full && !flush;
  assign out_valid = !empty;
`ifdef DEC2X4_SEQ_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (flush) count <= '0;
    else if (out_valid && out_ready && count != '1) count <= count + 1'b1;
`else
  assign count = '0;
`endif
endmodule

// File: tb/tb_dec2x4_seq.sv
// tb_dec2x4_seq: table-driven check of dec2x4_seq (DEPTH=2, CNT_W=4) plus reset and counter sequences
module tb_dec2x4_seq;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [1:0] in_code = 0;
  logic in_ready, out_valid;
  logic [3:0] out_onehot, count;
  int checks = 0, errors = 0, cnt_m = 0;
  typedef struct {
    logic fl, iv;
    logic [1:0] code;
    logic ordy, e_ir, e_ov;
    logic [3:0] e_oh;
  } vec_t;
  vec_t vt [20];

  dec2x4_seq #(.DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .out_valid(out_valid), .out_onehot(out_onehot),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_cnt(input int n);
`ifdef DEC2X4_SEQ_CNT_EN
    return n > 15 ? 4'd15 : 4'(n);
`else
    return 4'd0;
`endif
  endfunction

  initial begin
    //        fl iv code  ordy ir ov oh
    vt[0]  = '{0, 1, 2'b00, 1, 1, 0, 4'b0000};
    vt[1]  = '{0, 1, 2'b01, 1, 1, 1, 4'b0001};
    vt[2]  = '{0, 1, 2'b10, 1, 1, 1, 4'b0010};
    vt[3]  = '{0, 1, 2'b11, 1, 1, 1, 4'b0100};
    vt[4]  = '{0, 0, 2'b00, 1, 1, 1, 4'b1000};
    vt[5]  = '{0, 0, 2'b11, 0, 1, 0, 4'b0000};
    vt[6]  = '{0, 1, 2'b10, 0, 1, 0, 4'b0000};
    vt[7]  = '{0, 1, 2'b11, 0, 1, 1, 4'b0100};
    vt[8]  = '{0, 1, 2'b01, 0, 0, 1, 4'b0100};
    vt[9]  = '{0, 0, 2'b00, 1, 0, 1, 4'b0100};
    vt[10] = '{0, 0, 2'b00, 1, 1, 1, 4'b1000};
    vt[11] = '{0, 0, 2'b00, 0, 1, 0, 4'b0000};
    vt[12] = '{0, 1, 2'b11, 0, 1, 0, 4'b0000};
    vt[13] = '{0, 1, 2'b01, 1, 1, 1, 4'b1000};
    vt[14] = '{0, 0, 2'b00, 0, 1, 1, 4'b0010};
    vt[15] = '{0, 1, 2'b00, 0, 1, 1, 4'b0010};
    vt[16] = '{1, 1, 2'b10, 1, 0, 1, 4'b0010};
    vt[17] = '{0, 0, 2'b00, 0, 1, 0, 4'b0000};
    vt[18] = '{0, 1, 2'b01, 1, 1, 0, 4'b0000};
    vt[19] = '{0, 0, 2'b00, 1, 1, 1, 4'b0010};
    #2;
    chk("rst_ov", 8'(out_valid), 8'd0);
    chk("rst_oh", 8'(out_onehot), 8'd0);
    chk("rst_cnt", 8'(count), 8'd0);
    @(negedge clk);
    rst = 0;
    #1 chk("rel_ir", 8'(in_ready), 8'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      flush = vt[i].fl;
      in_valid = vt[i].iv;
      in_code = vt[i].code;
      out_ready = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_ir", i), 8'(in_ready), 8'(vt[i].e_ir));
      chk($sformatf("v%0d_ov", i), 8'(out_valid), 8'(vt[i].e_ov));
      chk($sformatf("v%0d_oh", i), 8'(out_onehot), 8'(vt[i].e_oh));
      chk($sformatf("v%0d_cnt", i), 8'(count), 8'(exp_cnt(cnt_m)));
      if (vt[i].fl) cnt_m = 0;
      else if (vt[i].e_ov && vt[i].ordy) cnt_m++;
    end
    // asynchronous reset between edges with two entries queued
    @(negedge clk);
    flush = 0; in_valid = 1; in_code = 2'b10; out_ready = 0;
    @(negedge clk);
    in_code = 2'b01;
    @(negedge clk);
    in_valid = 0;
    #1 chk("pre_rst_oh", 8'(out_onehot), 8'b0100);
    #2 rst = 1;
    #1;
    chk("mid_rst_ov", 8'(out_valid), 8'd0);
    chk("mid_rst_oh", 8'(out_onehot), 8'd0);
    chk("mid_rst_cnt", 8'(count), 8'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_ir", 8'(in_ready), 8'd1);
    chk("post_rst_ov", 8'(out_valid), 8'd0);
    in_valid = 1; in_code = 2'b11; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("post_rst_push_ov", 8'(out_valid), 8'd1);
    chk("post_rst_push_oh", 8'(out_onehot), 8'b1000);
    // counter saturation: 20 pops with CNT_W=4
    @(negedge clk);
    rst = 1;
    #1 rst = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1; in_code = 2'(i); out_ready = 1;
      #1;
      if (i > 0) begin
        chk($sformatf("sat%0d_oh", i), 8'(out_onehot), 8'(4'b0001 << ((i - 1) % 4)));
        chk($sformatf("sat%0d_cnt", i), 8'(count), 8'(exp_cnt(i - 1)));
      end
    end
    @(negedge clk);
    in_valid = 0;
    #1 chk("sat_final_cnt", 8'(count), 8'(exp_cnt(20)));
    @(negedge clk);
    #1 chk("sat_drained_ov", 8'(out_valid), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
